// File: rtl/bidicntr_pkg.sv
// Shared types and constants for the bidirectional counter decoder.
package bidicntr_pkg;

    typedef enum logic [1:0] {
        SYNC,
        ACQ,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        HOLD,
        UP,
        DOWN,
        JUMP
    } step_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bidicntr_if.sv
// Sample bus into the decoder and its decoded results back out.
interface bidicntr_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) ();

    logic              sample_en;
    logic [WIDTH-1:0]  count_in;
    logic              dir;
    logic              locked;
    logic              dir_chg;
    logic              wrap;
    logic              err;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output sample_en, count_in,
        input  dir, locked, dir_chg, wrap, err, wrap_cnt
    );

    modport slave (
        input  sample_en, count_in,
        output dir, locked, dir_chg, wrap, err, wrap_cnt
    );

endinterface

// File: rtl/bidicntr_step_cls.sv
// Combinational step classifier: sorts prev->count_in into HOLD/UP/DOWN/JUMP and flags wraps.
module bidicntr_step_cls
    import bidicntr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_t            step,
    output logic             wrap
);

    logic [WIDTH-1:0] delta;

    // Modular subtraction: max->0 reads as +1 and 0->max as -1.
    assign delta = count_in - prev;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        step = JUMP;
        wrap = 1'b0;
        if (delta == WIDTH'(1)) begin
            step = UP;
            wrap = (prev == '1);
        end else if (delta == '1) begin
            step = DOWN;
            wrap = (prev == '0);
        end else if (delta == '0) begin
            step = HOLD;
        end
    end

endmodule

// File: rtl/bidicntr_decoder.sv
// Decodes direction, lock, reversals, wraps and illegal jumps from a sampled counter bus.
// Optional wrap counter: define BIDICNTR_DEC_WRAP_CNT_EN to build it, otherwise wrap_cnt is 0.
module bidicntr_decoder
    import bidicntr_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int WRAP_W = 8
) (
    input  logic      clk,
    input  logic      reset,
    bidicntr_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       streak_q, streak_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             dir_chg_q, dir_chg_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    step_t            step;
    logic             step_wrap;
    logic             step_dir;

    bidicntr_step_cls #(.WIDTH(WIDTH)) u_step_cls (
        .prev     (prev_q),
        .count_in (bus.count_in),
        .step     (step),
        .wrap     (step_wrap)
    );

    assign step_dir = (step == UP) ? DIR_UP : DIR_DOWN;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state_q   <= SYNC;
            prev_q    <= '0;
            streak_q  <= '0;
            dir_q     <= DIR_DOWN;
            locked_q  <= 1'b0;
            dir_chg_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            streak_q  <= streak_d;
            dir_q     <= dir_d;
            locked_q  <= locked_d;
            dir_chg_q <= dir_chg_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        streak_d  = streak_q;
        dir_d     = dir_q;
        locked_d  = locked_q;
        dir_chg_d = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;

        if (bus.sample_en) begin
            prev_d = bus.count_in;
            unique case (state_q)
                SYNC: state_d = ACQ;

                ACQ: begin
                    if (step == UP || step == DOWN) begin
                        wrap_d = step_wrap;
                        if (step_dir == dir_q) begin
                            streak_d = streak_q + 4'd1;
                        end else begin
                            streak_d = 4'd1;
                            dir_d    = step_dir;
                        end
                        if (streak_d == 4'(LOCK_N)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (step == JUMP) begin
                        err_d    = 1'b1;
                        streak_d = '0;
                    end
                end

                LOCKED: begin
                    if (step == UP || step == DOWN) begin
                        wrap_d = step_wrap;
                        if (step_dir != dir_q) begin
                            dir_d     = step_dir;
                            dir_chg_d = 1'b1;
                        end
                    end else if (step == JUMP) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        streak_d = '0;
                        state_d  = ACQ;
                    end
                end

                default: state_d = SYNC;
            endcase
        end
    end

`ifdef BIDICNTR_DEC_WRAP_CNT_EN
    logic [WRAP_W-1:0] wrap_cnt_q;

    // Saturates at all ones; the wrap pulse itself keeps firing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt_q <= '0;
        end else if (wrap_d && wrap_cnt_q != '1) begin
            wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
        end
    end

    assign bus.wrap_cnt = wrap_cnt_q;
`else
    assign bus.wrap_cnt = '0;
`endif

    assign bus.dir     = dir_q;
    assign bus.locked  = locked_q;
    assign bus.dir_chg = dir_chg_q;
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bidicntr_decoder.sv
// Directed self-checking bench for bidicntr_decoder with hand-computed expectations.
module tb_bidicntr_decoder;

`ifdef BIDICNTR_DEC_WRAP_CNT_EN
    localparam bit WC_EN = 1'b1;
`else
    localparam bit WC_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   exp_wraps;
    int   cur;

    bidicntr_if #(.WIDTH(4), .WRAP_W(8)) bus ();

    bidicntr_decoder #(.WIDTH(4), .LOCK_N(2), .WRAP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic edir, input logic elock,
                              input logic echg, input logic ewrap, input logic eerr);
        check({tag, ".dir"},      32'(bus.dir),      32'(edir));
        check({tag, ".locked"},   32'(bus.locked),   32'(elock));
        check({tag, ".dir_chg"},  32'(bus.dir_chg),  32'(echg));
        check({tag, ".wrap"},     32'(bus.wrap),     32'(ewrap));
        check({tag, ".err"},      32'(bus.err),      32'(eerr));
        check({tag, ".wrap_cnt"}, 32'(bus.wrap_cnt), WC_EN ? 32'(exp_wraps) : 32'd0);
    endtask

    task automatic drive(input int v);
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.count_in  = 4'(v);
        @(posedge clk);
        #1;
        bus.sample_en = 1'b0;
    endtask

    // Drive one sample and check the registered response right after the edge.
    task automatic smp(input int v, input string tag, input logic edir, input logic elock,
                       input logic echg, input logic ewrap, input logic eerr);
        drive(v);
        if (ewrap && exp_wraps < 255) exp_wraps++;
        expect_all(tag, edir, elock, echg, ewrap, eerr);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        exp_wraps     = 0;
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        bus.count_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_all("reset", 0, 0, 0, 0, 0);

        // Up-count lock: sync capture, then two up steps lock.
        smp(0, "sync", 0, 0, 0, 0, 0);
        smp(1, "up1",  1, 0, 0, 0, 0);
        smp(2, "up2",  1, 1, 0, 0, 0);
        smp(3, "up3",  1, 1, 0, 0, 0);
        for (int v = 4; v <= 13; v++) smp(v, "uprun", 1, 1, 0, 0, 0);

        // Up wrap 15 -> 0.
        smp(14, "up14",   1, 1, 0, 0, 0);
        smp(15, "up15",   1, 1, 0, 0, 0);
        smp(0,  "upwrap", 1, 1, 0, 1, 0);
        smp(1,  "uppost", 1, 1, 0, 0, 0);
        for (int v = 2; v <= 5; v++) smp(v, "upto5", 1, 1, 0, 0, 0);

        // Reversal while locked.
        smp(4, "rev",  0, 1, 1, 0, 0);
        smp(3, "rev2", 0, 1, 0, 0, 0);

        // Down wrap 0 -> 15.
        smp(2,  "dn2",    0, 1, 0, 0, 0);
        smp(1,  "dn1",    0, 1, 0, 0, 0);
        smp(0,  "dn0",    0, 1, 0, 0, 0);
        smp(15, "dnwrap", 0, 1, 0, 1, 0);
        for (int v = 14; v >= 6; v--) smp(v, "dnrun", 0, 1, 0, 0, 0);

        // Illegal jump 6 -> 9, then relock upward.
        smp(9,  "jump",   0, 0, 0, 0, 1);
        smp(10, "reacq",  1, 0, 0, 0, 0);
        smp(11, "relock", 1, 1, 0, 0, 0);

        // Climb to 7 (wrapping once), then hold at 7.
        for (int v = 12; v <= 23; v++) smp(v % 16, "climb", 1, 1, 0, (v % 16) == 0, 0);
        repeat (5) smp(7, "hold", 1, 1, 0, 0, 0);

        // No sample: count_in moves but sample_en is low.
        @(negedge clk);
        bus.count_in = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        expect_all("idle", 1, 1, 0, 0, 0);
        smp(8, "afteridle", 1, 1, 0, 0, 0);

        // Reset while locked overrides a concurrent sample.
        @(negedge clk);
        reset         = 1'b1;
        bus.sample_en = 1'b1;
        bus.count_in  = 4'd9;
        @(posedge clk);
        #1;
        exp_wraps = 0;
        expect_all("midrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset         = 1'b0;
        bus.sample_en = 1'b0;
        smp(3, "resync",  0, 0, 0, 0, 0);
        smp(4, "restep",  1, 0, 0, 0, 0);
        smp(5, "relock2", 1, 1, 0, 0, 0);

        // Saturation: count up through many wraps, finishing on a 15 -> 0 step.
        cur = 5;
        repeat (16 * 260 + 11) begin
            cur = (cur + 1) % 16;
            drive(cur);
            if (cur == 0 && exp_wraps < 255) exp_wraps++;
        end
        expect_all("sat", 1, 1, 0, 1, 0);
        smp(1, "satpost", 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bidicntr_decoder.md
# bidicntr_decoder

Receive-side companion to the 4-bit up/down counter. It samples the counter's `count` bus and reconstructs the counting direction. It also detects terminal-count wrap-arounds and flags illegal jumps, such as glitches, missed samples or an unexpected reset. The block sits downstream of the counter as a monitor/decoder, so consumers can track direction and turns without access to `ctrl`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width; must be ≥2.
- `LOCK_N`, default 2: consecutive same-direction steps required to declare lock; range 1..15.
- `WRAP_W`, default 8: width of the wrap counter.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `sample_en`, input, 1: `count_in` is valid and is a new sample this cycle.
- `count_in`, input, WIDTH: counter value under observation.
- `dir`, output, 1: decoded direction; 1 = up, 0 = down.
- `locked`, output, 1: direction has been confirmed.
- `dir_chg`, output, 1: one-cycle pulse; direction reversed while locked.
- `wrap`, output, 1: one-cycle pulse; a legal step crossed max→0 (up) or 0→max (down).
- `err`, output, 1: one-cycle pulse; an illegal step was seen.
- `wrap_cnt`, output, WRAP_W: number of wraps since reset; saturating.

## Operation
- **Step classification.** Compute `delta = count_in − prev` modulo 2^WIDTH on each `sample_en`. The result is:
  - UP if delta = 1;
  - DOWN if delta = all ones;
  - HOLD if delta = 0;
  - JUMP otherwise.
- **Sample register.** `prev` is updated with `count_in` on every `sample_en`, including on a JUMP.
- **State machine:** SYNC → ACQ → LOCKED.
  - **SYNC** (reset state): the first `sample_en` only captures `prev`, then moves to ACQ. No step is classified and no pulse is produced.
  - **ACQ:**
    - On UP or DOWN: if the step matches `dir`, `streak` increments. Otherwise `streak` becomes 1 and `dir` takes the step's direction.
    - When `streak` reaches LOCK_N, the state moves to LOCKED and `locked` becomes 1.
    - HOLD: no change.
    - JUMP: `err` pulses and `streak` becomes 0.
  - **LOCKED:**
    - A step in the same direction keeps the state.
    - A step in the opposite direction flips `dir` and pulses `dir_chg`. The state remains LOCKED.
    - HOLD: no change.
    - JUMP: `err` pulses, `locked` becomes 0, `streak` becomes 0, and the state returns to ACQ.
- **Wrap detection.** `wrap` pulses on UP with `prev` = all ones, or on DOWN with `prev` = 0. This applies in both ACQ and LOCKED. Each wrap also increments `wrap_cnt`.
- **No sample.** While `sample_en` = 0 nothing changes and all pulses are 0.
- **Simultaneous events.**
  - A wrap on a reversing step in LOCKED raises both `wrap` and `dir_chg`.
  - `err` never coincides with `wrap` or `dir_chg`.
  - A step whose delta is both 1 and all ones cannot occur, because WIDTH ≥ 2.

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N.
- Latency: one cycle from sample to `dir`/`wrap`/`err`. `locked` rises LOCK_N+1 samples after reset: one sync sample plus LOCK_N steps.
- **Reset values:**
  - `dir` = 0, `locked` = 0, `dir_chg` = 0, `wrap` = 0, `err` = 0, `wrap_cnt` = 0;
  - state = SYNC, `streak` = 0, `prev` = 0.
- **Reset mid-operation** overrides any concurrent `sample_en`. The next sample after reset deasserts is treated as the SYNC capture.
- `wrap_cnt` saturates at 2^WRAP_W − 1; `wrap` keeps pulsing after saturation.

## Configuration
- `BIDICNTR_DEC_WRAP_CNT_EN`:
  - **Defined:** the WRAP_W-bit saturating counter drives `wrap_cnt`.
  - **Undefined:** no counter flops are built and `wrap_cnt` is tied to 0. The `wrap` pulse is unaffected.

## Structure
- **Shared package `bidicntr_pkg`:**
  - state enum {SYNC, ACQ, LOCKED};
  - step-class enum {HOLD, UP, DOWN, JUMP};
  - constants `DIR_UP` = 1 and `DIR_DOWN` = 0.
- **Sub-module `bidicntr_step_cls`:** a combinational classifier taking `prev` and `count_in` and producing the step class and a wrap flag. The FSM and counters stay in the top module.

## Test plan
- **Up-count lock:** reset for 2 cycles, then samples 0,1,2,3 each cycle with LOCK_N=2 → `locked` = 1 after the sample 2, and `dir` = 1; no `err`.
- **Up wrap:** locked up, samples 14,15,0 → `wrap` pulses once on the 15→0 step; `wrap_cnt` = 1 (0 if the macro is undefined).
- **Reversal while locked:** locked up at 5, then samples 4,3 → `dir_chg` pulses on the 5→4 step, `dir` = 0, `locked` stays 1.
- **Down wrap:** locked down, samples 1,0,15 → `wrap` on the 0→15 step; `wrap_cnt` increments.
- **Illegal jump:** locked at 6, sample 9 → `err` pulses, `locked` = 0; the following samples 10,11 relock with `dir` = 1.
- **Hold and reset mid-operation:**
  - `sample_en` held with a constant value 7 for 5 cycles → no state change and no pulses.
  - Reset asserted while locked → all outputs 0 the next cycle, and the next sample is only captured.
